pipeline_hazard_ctrl: RTL
=========================

Name: pipeline_hazard_ctrl

Overview:
- Sequencing controller for the 5-stage LEGv8 pipeline (IF, ID, EX, MEM, WB).
- Consumes decode-stage control fields and keeps an internal scoreboard of the instructions in EX, MEM and WB.
- From the scoreboard it drives PC/IF-ID stalls, IF-ID flush, ID-EX bubble insertion and operand-forwarding selects.
- Branches resolve in ID, so it also protects CBZ register reads and B.cond flag reads.

Parameters:
- REG_W, 5, register address width
- ZERO_REG, 31, XZR index; never causes a hazard or a forward
- CNT_W, 16, width of the performance counters

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- id_valid  in  1  ID holds a real instruction
- id_rn  in  5  first source register
- id_rm  in  5  second source (Rm for R-type, Rd for STUR/CBZ per Reg2Loc)
- id_use_rn  in  1  Rn is read
- id_use_rm  in  1  second source is read
- id_rd  in  5  destination register (X30 for BL)
- id_regwrite  in  1  RegWrite
- id_is_load  in  1  LDUR
- id_update  in  1  sets flags
- id_cond  in  1  B.cond
- id_cbz  in  1  CBZ
- id_branch  in  1  branch taken, resolved in ID
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  IF/ID loads a bubble at the next edge
- idex_bubble  out  1  ID/EX loads a bubble at the next edge
- fwd_a  out  2  EX operand A select: 00 regfile, 10 MEM, 01 WB
- fwd_b  out  2  EX operand B select, same encoding
- cbz_fwd  out  2  ID CBZ operand select, same encoding
- stall_cnt  out  CNT_W  stall cycles, saturating
- flush_cnt  out  CNT_W  flushes, saturating

Behaviour:
- Scoreboard
  - Three entries: EX, MEM, WB. Each holds {valid, rd, regwrite, is_load, update, rn, rm, use_rn, use_rm}.
  - Every clock: WB<=MEM and MEM<=EX.
  - EX<=ID fields when id_valid and no stall; otherwise EX<=invalid (bubble).
- Match rule: a match needs the entry valid, regwrite=1, rd==src, src!=ZERO_REG and the matching use_* bit set.
- Stall (combinational, only when id_valid):
  - Load-use: EX.is_load matches id_rn or id_rm.
  - CBZ: EX matches id_rm (any producer), or MEM.is_load matches id_rm.
  - B.cond: EX.update=1.
- On stall: pc_stall=ifid_stall=idex_bubble=1. id_branch is ignored that cycle, so ifid_flush=0.
- Flush: ifid_flush=1 when id_valid & id_branch & ~stall. ID/EX still advances; BL must reach WB.
- Stall and branch in the same cycle: the stall wins; the branch re-evaluates next cycle.
- Forwarding for the EX instruction:
  - fwd_a: 10 if MEM matches EX.rn; else 01 if WB matches; else 00. MEM has priority.
  - fwd_b: same rule on EX.rm.
  - Outputs are 00 when EX is invalid.
- cbz_fwd:
  - 10 if MEM is a non-load match on id_rm.
  - 01 if WB matches id_rm.
  - Else 00.
  - 00 when id_cbz=0.
- FSM (registered) states: RUN and STALL.
  - RUN->STALL when stall=1.
  - STALL->RUN when stall=0.
  - STALL->STALL when stall persists (the CBZ-after-load case lasts 2 cycles).
- Counters:
  - stall_cnt increments each cycle stall=1.
  - flush_cnt increments each cycle ifid_flush=1.
  - Both saturate at all-ones.
- Reset (asynchronous, reset_n=0):
  - All scoreboard entries invalid; FSM=RUN; counters=0.
  - All outputs 0 while reset is asserted.
  - Mid-operation reset kills in-flight entries immediately; no forward or stall is reported from pre-reset state.
- ZERO_REG: never a hazard or forward source, even when regwrite=1.

Decomposition:
- Shared package (pipe_ctrl_pkg):
  - sb_entry_t struct.
  - fwd_sel_t enum: FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - hz_state_t enum: RUN, STALL.
  - ZERO_REG constant.
- Sub-module: hazard_match, a combinational compare of an entry against a source register; instantiated per entry/source pair.

Test Plan:
- ADDS X1,X2,X3 then SUBS X4,X1,X5 -> no stall; second in EX shows fwd_a=10. An independent instruction between them -> fwd_a=01.
- LDUR X9,[X0,#0] then ADDS X3,X9,X2 -> 1 stall cycle (pc_stall=ifid_stall=idex_bubble=1, stall_cnt=1), then fwd_a=01.
- LDUR X7 then CBZ X7 -> 2 stall cycles, then cbz_fwd=01, stall_cnt=2. ADDI X7 then CBZ X7 -> 1 stall, then cbz_fwd=10.
- SUBS X31,X1,X2 then B.EQ taken -> 1 stall, then ifid_flush=1 for 1 cycle, flush_cnt=1. ADDI X31 then ADDS X1,X31,X2 -> no stall, fwd_a=00.
- reset_n low during a load-use stall -> outputs 0 immediately, counters 0; after release the first instruction sees no forwarding.
- Force 2^16+3 stall cycles -> stall_cnt holds 16'hFFFF.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types for the LEGv8 pipeline hazard controller: scoreboard entry,
// forwarding select encoding and sequencing FSM states.
package pipe_ctrl_pkg;

    // Register address width carried in scoreboard entries
    localparam int SB_REG_W = 5;

    // XZR index: reads as zero, writes are discarded
    localparam int ZERO_REG_DEF = 31;

    // One in-flight instruction as tracked in EX, MEM or WB
    typedef struct packed {
        logic                valid;
        logic [SB_REG_W-1:0] rd;
        logic                regwrite;
        logic                is_load;
        logic                update;
        logic [SB_REG_W-1:0] rn;
        logic [SB_REG_W-1:0] rm;
        logic                use_rn;
        logic                use_rm;
    } sb_entry_t;

    // Operand source select for the EX ALU inputs and the ID CBZ comparator
    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Sequencing state: free-running or holding the front end
    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hazard_match.sv
// Combinational compare of one scoreboard entry against one source register.
// A hit means the entry will write the register that the consumer reads.
module hazard_match #(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = pipe_ctrl_pkg::ZERO_REG_DEF
) (
    input  pipe_ctrl_pkg::sb_entry_t entry,
    input  logic [REG_W-1:0]         src,
    input  logic                     use_src,
    output logic                     match
);

    // Fields that only matter to other consumers of the entry
    logic unused_fields;

    assign unused_fields = ^{entry.is_load, entry.update, entry.rn, entry.rm,
                             entry.use_rn, entry.use_rm};

    // XZR is never a producer, so a write to it never creates a dependency
    assign match = entry.valid && entry.regwrite && use_src &&
                   (entry.rd == src) && (src != REG_W'(ZERO_REG));

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard and forwarding controller for a 5-stage LEGv8 pipeline with
// branches resolved in ID. Tracks EX/MEM/WB in a scoreboard and derives
// stalls, flushes, bubbles and forwarding selects from it.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_W    = 5,
    parameter int ZERO_REG = ZERO_REG_DEF,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             id_valid,
    input  logic [REG_W-1:0] id_rn,
    input  logic [REG_W-1:0] id_rm,
    input  logic             id_use_rn,
    input  logic             id_use_rm,
    input  logic [REG_W-1:0] id_rd,
    input  logic             id_regwrite,
    input  logic             id_is_load,
    input  logic             id_update,
    input  logic             id_cond,
    input  logic             id_cbz,
    input  logic             id_branch,
    output logic             pc_stall,
    output logic             ifid_stall,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic [1:0]       fwd_a,
    output logic [1:0]       fwd_b,
    output logic [1:0]       cbz_fwd,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    sb_entry_t id_e;
    sb_entry_t ex_e;
    sb_entry_t mem_e;
    sb_entry_t wb_e;
    hz_state_t state;
    hz_state_t next_state;

    logic ex_rn_hit;
    logic ex_rm_hit;
    logic mem_idrm_hit;
    logic wb_idrm_hit;
    logic mem_exrn_hit;
    logic wb_exrn_hit;
    logic mem_exrm_hit;
    logic wb_exrm_hit;
    logic load_use;
    logic cbz_hz;
    logic cond_hz;
    logic hz_stall;
    logic flush;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    // The nearer stage holds the younger value, so MEM beats WB
    function automatic fwd_sel_t fwd_pick(input logic mem_hit, input logic wb_hit);
        if (mem_hit) return FWD_MEM;
        if (wb_hit)  return FWD_WB;
        return FWD_RF;
    endfunction

    // Pack the decode-stage fields into a scoreboard entry
    always_comb begin
        id_e          = '0;
        id_e.valid    = id_valid;
        id_e.rd       = id_rd;
        id_e.regwrite = id_regwrite;
        id_e.is_load  = id_is_load;
        id_e.update   = id_update;
        id_e.rn       = id_rn;
        id_e.rm       = id_rm;
        id_e.use_rn   = id_use_rn;
        id_e.use_rm   = id_use_rm;
    end

    // ID sources against older producers
    hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_ex_rn   (.entry(ex_e),  .src(id_rn), .use_src(id_use_rn), .match(ex_rn_hit));
    hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_ex_rm   (.entry(ex_e),  .src(id_rm), .use_src(id_use_rm), .match(ex_rm_hit));
    hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_mem_idrm(.entry(mem_e), .src(id_rm), .use_src(id_use_rm), .match(mem_idrm_hit));
    hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_wb_idrm (.entry(wb_e),  .src(id_rm), .use_src(id_use_rm), .match(wb_idrm_hit));

    // EX sources against MEM and WB producers
    hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_mem_exrn(.entry(mem_e), .src(ex_e.rn), .use_src(ex_e.use_rn), .match(mem_exrn_hit));
    hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_wb_exrn (.entry(wb_e),  .src(ex_e.rn), .use_src(ex_e.use_rn), .match(wb_exrn_hit));
    hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_mem_exrm(.entry(mem_e), .src(ex_e.rm), .use_src(ex_e.use_rm), .match(mem_exrm_hit));
    hazard_match #(.REG_W(REG_W), .ZERO_REG(ZERO_REG)) u_wb_exrm (.entry(wb_e),  .src(ex_e.rm), .use_src(ex_e.use_rm), .match(wb_exrm_hit));

    // Stall causes: load-use, CBZ reading a not-yet-available register, B.cond after a flag setter
    always_comb begin
        load_use = ex_e.is_load && (ex_rn_hit || ex_rm_hit);
        cbz_hz   = id_cbz && (ex_rm_hit || (mem_e.is_load && mem_idrm_hit));
        cond_hz  = id_cond && ex_e.valid && ex_e.update;
        hz_stall = id_valid && (load_use || cbz_hz || cond_hz);
        flush    = id_valid && id_branch && !hz_stall;
    end

    // Drive the pipeline controls; everything reads zero while reset is held
    always_comb begin
        pc_stall    = 1'b0;
        ifid_stall  = 1'b0;
        idex_bubble = 1'b0;
        ifid_flush  = 1'b0;
        fwd_a       = FWD_RF;
        fwd_b       = FWD_RF;
        cbz_fwd     = FWD_RF;
        if (reset_n) begin
            pc_stall    = hz_stall;
            ifid_stall  = hz_stall;
            idex_bubble = hz_stall;
            ifid_flush  = flush;
            if (ex_e.valid) begin
                fwd_a = fwd_pick(mem_exrn_hit, wb_exrn_hit);
                fwd_b = fwd_pick(mem_exrm_hit, wb_exrm_hit);
            end
            // A load in MEM has no data yet, so only a non-load may feed CBZ from MEM
            if (id_valid && id_cbz) begin
                cbz_fwd = fwd_pick(mem_idrm_hit && !mem_e.is_load, wb_idrm_hit);
            end
        end
    end

    // Advance the scoreboard; a stall inserts a bubble into EX
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_e  <= '0;
            mem_e <= '0;
            wb_e  <= '0;
        end else begin
            wb_e  <= mem_e;
            mem_e <= ex_e;
            ex_e  <= (id_valid && !hz_stall) ? id_e : '0;
        end
    end

    // Sequencing state register
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RUN;
        end else begin
            state <= next_state;
        end
    end

    // Next-state: hold STALL for as long as the hazard persists
    always_comb begin
        next_state = state;
        case (state)
            RUN:     if (hz_stall)  next_state = STALL;
            STALL:   if (!hz_stall) next_state = RUN;
            default: next_state = RUN;
        endcase
    end

    // Saturating performance counters
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (hz_stall) stall_cnt <= sat_inc(stall_cnt);
            if (flush)    flush_cnt <= sat_inc(flush_cnt);
        end
    end

endmodule
